tblink_rpc_host: RTL and testbench

TBLINK_RPC_HOST -- requirements
Module: tblink_rpc_host

---
 rtl/tblink_rpc_host.sv | 140 ++++++++++++++
 tb/tb_tblink_rpc_host.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_host.sv
// Host-side RPC link: sends one command byte per request and decodes the
// controller's response stream (event header, or data header plus data byte).
module tblink_rpc_host #(
   parameter int unsigned TIMEOUT = 200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [5:0] req_cnt,
   output logic       c_valid,
   input  logic       c_ready,
   output logic [7:0] c_dat,
   input  logic       r_valid,
   output logic       r_ready,
   input  logic [7:0] r_dat,
   output logic       done,
   output logic       done_kind,
   output logic [7:0] done_data,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_HDR  = 2'd2,
      WAIT_DATA = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t     state_r, state_s;
   logic [7:0] cmd_r, cmd_s;
   logic [7:0] wait_cnt_r, wait_cnt_s;
   logic       done_r, done_s;
   logic       done_kind_r, done_kind_s;
   logic [7:0] done_data_r, done_data_s;
   logic       err_r, err_s;

   // Next-state, command capture, wait counter and completion pulses
   always_comb begin
      state_s     = state_r;
      cmd_s       = cmd_r;
      wait_cnt_s  = 8'd0;
      done_s      = 1'b0;
      done_kind_s = 1'b0;
      done_data_s = 8'h00;
      err_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               cmd_s = {req_cnt, req_op};
               if (req_op[1] == 1'b0) begin
                  state_s = SEND;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (c_ready) begin
               state_s = WAIT_HDR;
            end else begin
               state_s = SEND;
            end
         end
         WAIT_HDR: begin
            // A byte arriving on the last allowed cycle beats the timeout
            if (r_valid) begin
               case (r_dat)
                  8'h00: state_s = WAIT_DATA;
                  8'h01: begin
                     done_s      = 1'b1;
                     done_kind_s = 1'b1;
                     state_s     = IDLE;
                  end
                  default: begin
                     err_s   = 1'b1;
                     state_s = IDLE;
                  end
               endcase
            end else if (wait_cnt_r == TIMEOUT_LAST) begin
               err_s   = 1'b1;
               state_s = IDLE;
            end else begin
               wait_cnt_s = wait_cnt_r + 8'd1;
            end
         end
         WAIT_DATA: begin
            if (r_valid) begin
               done_s      = 1'b1;
               done_data_s = r_dat;
               state_s     = IDLE;
            end else if (wait_cnt_r == TIMEOUT_LAST) begin
               err_s   = 1'b1;
               state_s = IDLE;
            end else begin
               wait_cnt_s = wait_cnt_r + 8'd1;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         cmd_r       <= 8'h00;
         wait_cnt_r  <= 8'd0;
         done_r      <= 1'b0;
         done_kind_r <= 1'b0;
         done_data_r <= 8'h00;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         cmd_r       <= cmd_s;
         wait_cnt_r  <= wait_cnt_s;
         done_r      <= done_s;
         done_kind_r <= done_kind_s;
         done_data_r <= done_data_s;
         err_r       <= err_s;
      end
   end

   assign req_ready = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign c_valid   = (state_r == SEND);
   assign c_dat     = (state_r == SEND) ? cmd_r : 8'h00;
   assign r_ready   = (state_r == WAIT_HDR) || (state_r == WAIT_DATA);
   assign done      = done_r;
   assign done_kind = done_kind_r;
   assign done_data = done_data_r;
   assign err       = err_r;

endmodule

// File: tb/tb_tblink_rpc_host.sv
// Directed bench for tblink_rpc_host with a short TIMEOUT to exercise expiry.
module tb_tblink_rpc_host;
   localparam int unsigned TMO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [5:0] req_cnt = 6'd0;
   logic       c_valid;
   logic       c_ready = 1'b0;
   logic [7:0] c_dat;
   logic       r_valid = 1'b0;
   logic       r_ready;
   logic [7:0] r_dat = 8'h00;
   logic       done;
   logic       done_kind;
   logic [7:0] done_data;
   logic       err;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   int n_err = 0;
   int n_xfer = 0;
   int n_both = 0;

   tblink_rpc_host #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cnt(req_cnt),
      .c_valid(c_valid), .c_ready(c_ready), .c_dat(c_dat),
      .r_valid(r_valid), .r_ready(r_ready), .r_dat(r_dat),
      .done(done), .done_kind(done_kind), .done_data(done_data),
      .err(err), .busy(busy)
   );

   always #5 clock = ~clock;

   // Event monitors sampled at the active edge
   always @(posedge clock) begin
      if (done) n_done <= n_done + 1;
      if (err) n_err <= n_err + 1;
      if (done && err) n_both <= n_both + 1;
      if (c_valid && c_ready) n_xfer <= n_xfer + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one request for a single accepting edge
   task automatic issue(input logic [1:0] op, input logic [5:0] cnt);
      req_valid = 1'b1; req_op = op; req_cnt = cnt;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({req_ready, c_valid, c_dat, r_ready, done, done_kind, done_data, err, busy} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_vals got rr=%b cv=%b cd=%h rdy=%b d=%b k=%b dd=%h e=%b b=%b",
                  req_ready, c_valid, c_dat, r_ready, done, done_kind, done_data, err, busy);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_sample();
      issue(2'b00, 6'd0);
      checks++;
      if ({c_valid, c_dat, busy, req_ready, r_ready} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sample_send got cv=%b cd=%h b=%b rr=%b r=%b want 1 00 1 0 0",
                  c_valid, c_dat, busy, req_ready, r_ready);
      end
      c_ready = 1'b1;
      tick();
      c_ready = 1'b0;
      checks++;
      if ({r_ready, c_valid, c_dat} !== {1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL sample_hdr got r=%b cv=%b cd=%h want 1 0 00", r_ready, c_valid, c_dat);
      end
      r_valid = 1'b1; r_dat = 8'h00;
      tick();
      r_dat = 8'hA5;
      tick();
      r_valid = 1'b0;
      checks++;
      if ({done, done_kind, done_data, err, busy} !== {1'b1, 1'b0, 8'hA5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sample_done got d=%b k=%b dd=%h e=%b b=%b want 1 0 a5 0 0",
                  done, done_kind, done_data, err, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse got %b want 0", done);
      end
   endtask

   task automatic test_advance();
      int d0;
      d0 = n_done;
      issue(2'b01, 6'd5);
      checks++;
      if (c_dat !== 8'h15) begin
         errors++;
         $display("FAIL adv_cmd got %h want 15", c_dat);
      end
      c_ready = 1'b1;
      tick();
      c_ready = 1'b0;
      r_valid = 1'b1; r_dat = 8'h01;
      tick();
      r_valid = 1'b0;
      // third edge after acceptance: minimum latency
      checks++;
      if ({done, done_kind, done_data, err} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL adv_done got d=%b k=%b dd=%h e=%b want 1 1 00 0", done, done_kind, done_data, err);
      end
      tick();
      checks++;
      if (n_done - d0 !== 1) begin
         errors++;
         $display("FAIL adv_count got %0d want 1", n_done - d0);
      end
   endtask

   task automatic test_back_to_back();
      int x0;
      x0 = n_xfer;
      issue(2'b01, 6'd5);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({c_valid, c_dat} !== {1'b1, 8'h15}) begin
            errors++;
            $display("FAIL bp_hold%0d got cv=%b cd=%h want 1 15", i, c_valid, c_dat);
         end
         tick();
      end
      c_ready = 1'b1;
      tick();
      c_ready = 1'b0;
      checks++;
      if ({c_valid, r_ready} !== 2'b01 || n_xfer - x0 !== 1) begin
         errors++;
         $display("FAIL bp_xfer got cv=%b r=%b xfers=%0d want 0 1 1", c_valid, r_ready, n_xfer - x0);
      end
      r_valid = 1'b1; r_dat = 8'h01;
      tick();
      r_valid = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int d0, e0;
      d0 = n_done; e0 = n_err;
      issue(2'b00, 6'd0);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick();
      checks++;
      if ({err, busy} !== 2'b01) begin
         errors++;
         $display("FAIL tmo_early got e=%b b=%b want 0 1", err, busy);
      end
      tick();
      checks++;
      if ({err, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL tmo_fire got e=%b b=%b d=%b want 1 0 0", err, busy, done);
      end
      tick();
      checks++;
      if (n_err - e0 !== 1 || n_done !== d0) begin
         errors++;
         $display("FAIL tmo_count got errs=%0d dones=%0d want 1 0", n_err - e0, n_done - d0);
      end
      // response on the final permitted cycle wins
      e0 = n_err;
      issue(2'b01, 6'd1);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick();
      r_valid = 1'b1; r_dat = 8'h01;
      tick();
      r_valid = 1'b0;
      checks++;
      if ({done, done_kind, err} !== 3'b110) begin
         errors++;
         $display("FAIL tmo_last got d=%b k=%b e=%b want 1 1 0", done, done_kind, err);
      end
      tick();
      checks++;
      if (n_err !== e0) begin
         errors++;
         $display("FAIL tmo_last_err got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_errors();
      int x0;
      x0 = n_xfer;
      issue(2'b10, 6'd3);
      checks++;
      if ({err, c_valid, busy, done} !== 4'b1000) begin
         errors++;
         $display("FAIL rsv_op got e=%b cv=%b b=%b d=%b want 1 0 0 0", err, c_valid, busy, done);
      end
      tick();
      checks++;
      if (err !== 1'b0 || n_xfer !== x0) begin
         errors++;
         $display("FAIL rsv_after got e=%b xfers=%0d want 0 0", err, n_xfer - x0);
      end
      issue(2'b00, 6'd0);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      r_valid = 1'b1; r_dat = 8'h07;
      tick();
      r_valid = 1'b0;
      checks++;
      if ({err, done, busy, req_ready} !== 4'b1001) begin
         errors++;
         $display("FAIL bad_hdr got e=%b d=%b b=%b rr=%b want 1 0 0 1", err, done, busy, req_ready);
      end
      tick();
      // event header after sample is still an event, no err
      issue(2'b00, 6'd0);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      r_valid = 1'b1; r_dat = 8'h01;
      tick();
      r_valid = 1'b0;
      checks++;
      if ({done, done_kind, err} !== 3'b110) begin
         errors++;
         $display("FAIL mismatch got d=%b k=%b e=%b want 1 1 0", done, done_kind, err);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int d0, e0;
      issue(2'b00, 6'd0);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      r_valid = 1'b1; r_dat = 8'h00; tick(); r_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({req_ready, c_valid, c_dat, r_ready, done, done_kind, done_data, err, busy} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid got rr=%b cv=%b r=%b b=%b", req_ready, c_valid, r_ready, busy);
      end
      tick();
      reset = 1'b0;
      d0 = n_done; e0 = n_err;
      tick(); tick();
      issue(2'b00, 6'd0);
      c_ready = 1'b1; tick(); c_ready = 1'b0;
      r_valid = 1'b1; r_dat = 8'h00; tick();
      r_dat = 8'h3C; tick();
      r_valid = 1'b0;
      checks++;
      if ({done, done_kind, done_data} !== {1'b1, 1'b0, 8'h3C}) begin
         errors++;
         $display("FAIL rst_recover got d=%b k=%b dd=%h want 1 0 3c", done, done_kind, done_data);
      end
      tick();
      checks++;
      if (n_done - d0 !== 1 || n_err !== e0) begin
         errors++;
         $display("FAIL rst_pulses got dones=%0d errs=%0d want 1 0", n_done - d0, n_err - e0);
      end
   endtask

   initial begin
      test_reset();
      test_sample();
      test_advance();
      test_back_to_back();
      test_timeout();
      test_errors();
      test_reset_mid();
      checks++;
      if (n_both !== 0) begin
         errors++;
         $display("FAIL done_err_overlap got %0d want 0", n_both);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
